instr_encoder_loader: RTL and testbench

- Inverse of the instruction field decoder. Accepts RISC-V RV32I fields plus a format code over a valid/ready handshake.
- Packs the fields into a 32-bit instruction word according to the format.
- Writes consecutive words into instruction memory through a simple write port.
- Used by the testbench/boot path to load programs into the single-cycle core's instruction memory before the core is released.

---
 rtl/instr_encoder_loader.sv | 113 +++++++++++
 tb/tb_instr_encoder_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Packs RV32I fields into instruction words and streams them into instruction memory.
// One-cycle write latency after each accepted bundle; in_ready drops when full or outside a session.
module instr_encoder_loader #(
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 32,
  parameter int BASE_ADDR = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       finish,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 fmt,
  input  logic [6:0]                 opcode,
  input  logic [4:0]                 rd,
  input  logic [2:0]                 funct3,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [6:0]                 funct7,
  input  logic [31:0]                imm,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]     LAST_C  = CW'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       enc;
  logic              legal, xfer, wr;

  always_comb begin
    in_ready = (state == LOAD) && (count < DEPTH_C);
    busy     = (state == LOAD);
    done     = (state == DONE);
    legal    = (fmt <= 3'd5);
    xfer     = in_valid && in_ready;
    wr       = xfer && legal;
  end

  always_comb begin
    enc = 32'h0;
    case (fmt)
      3'd0: enc = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: enc = {imm[11:0], rs1, funct3, rd, opcode};
      3'd2: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      3'd3: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      3'd4: enc = {imm[31:12], rd, opcode};
      3'd5: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: enc = 32'h0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = LOAD;
      LOAD: begin
        if (start)
          state_nxt = LOAD;
        else if (finish || (wr && count == LAST_C))
          state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A transfer coinciding with a restart still writes at the old pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= BASE_C;
      count     <= '0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_C;
      mem_wdata <= 32'h0;
    end else begin
      mem_we <= wr;
      if (wr) begin
        mem_addr  <= ptr;
        mem_wdata <= enc;
      end
      if (start) begin
        ptr   <= BASE_C;
        count <= '0;
        err   <= 1'b0;
      end else begin
        if (wr) begin
          ptr   <= ptr + ADDR_W'(4);
          count <= count + CW'(1);
        end
        if (xfer && !legal) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized and directed scoreboard bench for instr_encoder_loader (DEPTH=4).
module tb_instr_encoder_loader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, start, finish, in_valid;
  logic        in_ready, mem_we, busy, done, err;
  logic [2:0]  fmt, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, mem_addr, mem_wdata;
  logic [2:0]  count;

  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
    .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference session state
  bit          m_load, m_done, m_err;
  int          m_cnt;
  logic [31:0] m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_enc(input logic [2:0] f, input logic [31:0] op,
      input logic [31:0] d, input logic [31:0] f3, input logic [31:0] r1,
      input logic [31:0] r2, input logic [31:0] f7, input logic [31:0] im);
    logic [31:0] common;
    common = (r1 << 15) | (f3 << 12) | op;
    case (f)
      3'd0: return (f7 << 25) | (r2 << 20) | common | (d << 7);
      3'd1: return ((im & 32'hFFF) << 20) | common | (d << 7);
      3'd2: return (((im >> 5) & 32'h7F) << 25) | (r2 << 20) | common | ((im & 32'h1F) << 7);
      3'd3: return (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (r2 << 20) | common
                   | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7);
      3'd4: return (im & 32'hFFFFF000) | (d << 7) | op;
      3'd5: return (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 1) << 20)
                   | (((im >> 12) & 32'hFF) << 12) | (d << 7) | op;
      default: return 32'h0;
    endcase
  endfunction

  task automatic set_b(input logic [2:0] fm, input logic [6:0] op, input logic [4:0] d,
      input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
      input logic [6:0] f7, input logic [31:0] im);
    fmt = fm; opcode = op; rd = d; funct3 = f3; rs1 = r1; rs2 = r2; funct7 = f7; imm = im;
  endtask

  task automatic set_rand(input bit allow_illegal);
    logic [2:0] fm;
    fm = 3'($urandom_range(0, 5));
    if (allow_illegal && ($urandom % 8 == 0)) fm = 3'($urandom_range(6, 7));
    set_b(fm, 7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
          7'($urandom), $urandom);
  endtask

  // Called at a negedge: checks outputs against the model, drives inputs for the
  // next rising edge, advances the model, then waits for the following negedge.
  task automatic step(input bit s, input bit f, input bit v,
                      input bit use_lit = 1'b0, input logic [31:0] lit = 32'h0);
    bit ready;
    ready = m_load && (m_cnt < DEPTH);
    chk("in_ready", 32'(in_ready), 32'(ready));
    chk("busy", 32'(busy), 32'(m_load));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
    chk("count", 32'(count), 32'(m_cnt));
    start = s; finish = f; in_valid = v;
    if (v && ready) begin
      if (fmt <= 3'd5) begin
        q.push_back('{m_ptr,
                      use_lit ? lit : model_enc(fmt, 32'(opcode), 32'(rd), 32'(funct3),
                                                32'(rs1), 32'(rs2), 32'(funct7), imm),
                      m_cnt + 1});
        m_ptr += 4;
        m_cnt++;
      end else begin
        m_err = 1'b1;
      end
    end
    if (s) begin
      m_load = 1'b1; m_done = 1'b0; m_ptr = 0; m_cnt = 0; m_err = 1'b0;
    end else if (m_load && (f || m_cnt == DEPTH)) begin
      m_load = 1'b0; m_done = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic chk_reset();
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    m_load = 1'b0; m_done = 1'b0; m_err = 1'b0; m_cnt = 0; m_ptr = 0;
    @(negedge clk);
    chk_reset();
    reset = 1'b0;
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%h data=%h required no write at %0t",
                 mem_addr, mem_wdata, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.data);
        chk("wr_count", 32'(count), 32'(e.cnt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    set_b(3'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    do_reset();

    // addi x1,x0,5
    step(1, 0, 0);
    set_b(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
    step(0, 0, 1, 1, 32'h00500093);
    step(0, 0, 0);

    // R, S, B, U back-to-back fill the 4-deep session
    step(1, 0, 0);
    set_b(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    step(0, 0, 1, 1, 32'h002081B3);
    set_b(3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
    step(0, 0, 1, 1, 32'h0020A423);
    set_b(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd8);
    step(0, 0, 1, 1, 32'h00208463);
    set_b(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000);
    step(0, 0, 1, 1, 32'h123452B7);
    step(0, 0, 0);
    step(0, 0, 0);

    // jal x1,+16 in a fresh session
    step(1, 0, 0);
    set_b(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd16);
    step(0, 0, 1, 1, 32'h010000EF);
    step(0, 0, 0);

    // six bundles held valid: only DEPTH accepted
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      set_rand(0);
      step(0, 0, 1);
    end
    step(0, 0, 0);
    chk("full_done", 32'(done), 32'h1);
    chk("full_count", 32'(count), 32'(DEPTH));

    // illegal format between two legal bundles, then finish and restart
    step(1, 0, 0);
    set_b(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
    step(0, 0, 1, 1, 32'h00500093);
    set_b(3'd7, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd7);
    step(0, 0, 1);
    set_b(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    step(0, 0, 1, 1, 32'h002081B3);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("illegal_err", 32'(err), 32'h1);
    chk("illegal_done", 32'(done), 32'h1);
    step(1, 0, 0);
    set_b(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000);
    step(0, 0, 1, 1, 32'h123452B7);
    step(0, 0, 0);

    // reset in the cycle after a transfer
    step(1, 0, 0);
    set_rand(0);
    step(0, 0, 1);
    do_reset();
    @(negedge clk);
    chk("post_rst_we", 32'(mem_we), 32'h0);
    step(0, 0, 0);
    step(0, 1, 0);

    // random sessions
    for (int i = 0; i < 2000; i++) begin
      bit s, f, v;
      s = ($urandom % 20 == 0);
      f = ($urandom % 25 == 0);
      v = ($urandom % 3 != 0) && !s;
      set_rand(1);
      step(s, f, v);
    end
    step(0, 0, 0);
    step(0, 0, 0);
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
